// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU memory arbiter.
// Holds default widths, the arbiter state encoding and the bus-owner encoding.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_fetch_buf.sv
// One-entry fetch buffer: remembers the last fetched (address, word) pair.
// Ports:
//   clk, rst           clock, synchronous active-high reset (clears valid)
//   fill_i             a fetch completed on the bus this cycle
//   fill_addr_i/data_i address and word of that fetch
//   inval_i            a data write completed on the bus this cycle
//   inval_waddr_i      word address (addr[ADDR_W-1:2]) of that write
//   lookup_ce_i        fetch request active
//   lookup_addr_i      fetch address to compare
//   hit_o              combinational hit: request active, valid, address equal
//   data_o             buffered word
module mem_arbiter_fetch_buf #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              inval_i,
  input  logic [ADDR_W-3:0] inval_waddr_i,
  input  logic              lookup_ce_i,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] word_q;

  // Fill and invalidate come from different bus owners, so they never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      word_q  <= '0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      addr_q  <= fill_addr_i;
      word_q  <= fill_data_i;
    end else if (inval_i && (inval_waddr_i == addr_q[ADDR_W-1:2])) begin
      valid_q <= 1'b0;
    end
  end

  assign hit_o  = lookup_ce_i & valid_q & (lookup_addr_i == addr_q);
  assign data_o = word_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port arbiter between the instruction-fetch and data-access ports.
// MEM has priority over IF; each access is issued once and held until ack.
// stallreq_o stays high until every access requested this step has completed;
// a cycle with stallreq_o low is a pipeline release and clears the done flags.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_ce_i/if_addr_i        fetch request; if_data_o returns the word
//   mem_ce_i/we/sel/addr/wdata  data request; mem_rdata_o returns load data
//   stallreq_o               stall to pipeline controller (combinational)
//   bus_*_o / bus_*_i        registered req/ack memory bus
// Build option: define ARB_FETCH_BUF_EN to add a one-entry fetch buffer.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_ce_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_data_o,
  input  logic                mem_ce_i,
  input  logic                mem_we_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                stallreq_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  input  logic                bus_ack_i
);

  localparam int unsigned SEL_W = DATA_W / 8;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [DATA_W-1:0] if_q, if_d;
  logic [DATA_W-1:0] mem_q, mem_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

  logic              buf_hit;
  logic [DATA_W-1:0] buf_data;
  logic              hit_c;
  logic              mem_pend;
  logic              if_pend;
  logic              stall_c;
  logic              ack_c;

  assign ack_c = (state_q == ST_BUSY) & bus_ack_i;

`ifdef ARB_FETCH_BUF_EN
  mem_arbiter_fetch_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fetch_buf (
    .clk           (clk),
    .rst           (rst),
    .fill_i        (ack_c & (owner_q == OWN_IF)),
    .fill_addr_i   (bus_addr_q),
    .fill_data_i   (bus_rdata_i),
    .inval_i       (ack_c & (owner_q == OWN_MEM) & bus_we_q),
    .inval_waddr_i (bus_addr_q[ADDR_W-1:2]),
    .lookup_ce_i   (if_ce_i),
    .lookup_addr_i (if_addr_i),
    .hit_o         (buf_hit),
    .data_o        (buf_data)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  // A buffer hit counts as a completed fetch for this step.
  assign hit_c      = buf_hit & ~rst;
  assign mem_pend   = mem_ce_i & ~mem_done_q;
  assign if_pend    = if_ce_i & ~(if_done_q | hit_c);
  assign stall_c    = (mem_pend | if_pend) & ~rst;
  assign stallreq_o = stall_c;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_pend || if_pend) state_d = ST_BUSY;
      ST_BUSY: if (bus_ack_i)           state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus issue, return-data capture and done-flag bookkeeping.
  always_comb begin
    owner_d     = owner_q;
    if_done_d   = if_done_q;
    mem_done_d  = mem_done_q;
    if_d        = if_q;
    mem_d       = mem_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    case (state_q)
      ST_IDLE: begin
        bus_req_d = 1'b0;
        if (mem_pend) begin
          owner_d     = OWN_MEM;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_sel_d   = mem_sel_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
        end else if (if_pend) begin
          owner_d     = OWN_IF;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_sel_d   = {SEL_W{1'b1}};
          bus_addr_d  = if_addr_i;
          bus_wdata_d = '0;
        end
      end
      ST_BUSY: begin
        if (bus_ack_i) begin
          bus_req_d = 1'b0;
          if (owner_q == OWN_MEM) begin
            mem_d      = bus_rdata_i;
            mem_done_d = 1'b1;
          end else begin
            if_d      = bus_rdata_i;
            if_done_d = 1'b1;
          end
        end
      end
      default: bus_req_d = 1'b0;
    endcase
    // Release wins: a flag set by a dropped requester is stale for the next step.
    if (!stall_c) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= OWN_IF;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_q        <= '0;
      mem_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_q        <= if_d;
      mem_q       <= mem_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign if_data_o   = hit_c ? buf_data : if_q;
  assign mem_rdata_o = mem_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, load+fetch, store+fetch, reset during
// a transaction, spurious/held ack and (with ARB_FETCH_BUF_EN) the fetch buffer.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  int n_cmp = 0;
  int n_err = 0;
  int stall_cnt = 0;
  int n_xfer = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .if_ce_i     (if_ce_i),
    .if_addr_i   (if_addr_i),
    .if_data_o   (if_data_o),
    .mem_ce_i    (mem_ce_i),
    .mem_we_i    (mem_we_i),
    .mem_sel_i   (mem_sel_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_rdata_o (mem_rdata_o),
    .stallreq_o  (stallreq_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_sel_o   (bus_sel_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i)
  );

  always @(negedge clk) if (stallreq_o) stall_cnt++;
  always @(posedge clk) if (bus_req_o && bus_ack_i) n_xfer++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve one bus transaction that the DUT is issuing this cycle.
  task automatic serve(input string tag, input logic we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int waits, input logic [31:0] rdata);
    tick();
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = rdata;
      end
      @(negedge clk);
      check_eq({tag, "_req"},   32'(bus_req_o), 32'd1);
      check_eq({tag, "_we"},    32'(bus_we_o), 32'(we));
      check_eq({tag, "_sel"},   32'(bus_sel_o), 32'(sel));
      check_eq({tag, "_addr"},  bus_addr_o, addr);
      check_eq({tag, "_stall"}, 32'(stallreq_o), 32'd1);
      if (we) check_eq({tag, "_wdata"}, bus_wdata_o, wdata);
      tick();
    end
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'hCCCC_CCCC;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_ce_i = 1'b0; if_addr_i = '0; mem_ce_i = 1'b0; mem_we_i = 1'b0;
    mem_sel_i = '0; mem_addr_i = '0; mem_wdata_i = '0; bus_rdata_i = '0; bus_ack_i = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check_eq("rst_req",   32'(bus_req_o), 32'd0);
    check_eq("rst_we",    32'(bus_we_o), 32'd0);
    check_eq("rst_sel",   32'(bus_sel_o), 32'd0);
    check_eq("rst_addr",  bus_addr_o, 32'd0);
    check_eq("rst_wdata", bus_wdata_o, 32'd0);
    check_eq("rst_ifd",   if_data_o, 32'd0);
    check_eq("rst_memd",  mem_rdata_o, 32'd0);
    check_eq("rst_stall", 32'(stallreq_o), 32'd0);
    tick();
    rst = 1'b0;

    // Fetch only, 2 wait cycles: stall for 4 cycles then one release cycle.
    stall_cnt = 0; n_xfer = 0;
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0010;
    @(negedge clk);
    check_eq("t1_stall0", 32'(stallreq_o), 32'd1);
    check_eq("t1_req0",   32'(bus_req_o), 32'd0);
    serve("t1", 1'b0, 4'hF, 32'h0000_0010, 32'h0, 2, 32'h3401_0020);
    @(negedge clk);
    check_eq("t1_rel_stall", 32'(stallreq_o), 32'd0);
    check_eq("t1_ifd",       if_data_o, 32'h3401_0020);
    check_eq("t1_rel_req",   32'(bus_req_o), 32'd0);
    check_eq("t1_stall_cnt", 32'(stall_cnt), 32'd4);
    check_eq("t1_xfers",     32'(n_xfer), 32'd1);
    tick();
    if_ce_i = 1'b0;

    // Load plus fetch: MEM first, then IF, then release.
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h100;
    if_ce_i = 1'b1; if_addr_i = 32'h14;
    @(negedge clk);
    check_eq("t2_stall0", 32'(stallreq_o), 32'd1);
    serve("t2m", 1'b0, 4'hF, 32'h100, 32'h0, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    check_eq("t2_gap_stall", 32'(stallreq_o), 32'd1);
    check_eq("t2_gap_req",   32'(bus_req_o), 32'd0);
    serve("t2i", 1'b0, 4'hF, 32'h14, 32'h0, 0, 32'h0000_0013);
    @(negedge clk);
    check_eq("t2_rel_stall", 32'(stallreq_o), 32'd0);
    check_eq("t2_memd",      mem_rdata_o, 32'hDEAD_BEEF);
    check_eq("t2_ifd",       if_data_o, 32'h0000_0013);
    tick();
    mem_ce_i = 1'b0; if_ce_i = 1'b0;

    // Byte store plus fetch: write goes out first with stable sel/wdata.
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0010; mem_addr_i = 32'h200;
    mem_wdata_i = 32'h0000_AB00; if_ce_i = 1'b1; if_addr_i = 32'h18;
    serve("t3s", 1'b1, 4'b0010, 32'h200, 32'h0000_AB00, 2, 32'h5555_5555);
    serve("t3i", 1'b0, 4'hF, 32'h18, 32'h0, 0, 32'h00A0_0093);
    @(negedge clk);
    check_eq("t3_rel_stall", 32'(stallreq_o), 32'd0);
    check_eq("t3_ifd",       if_data_o, 32'h00A0_0093);
    check_eq("t3_memd",      mem_rdata_o, 32'h5555_5555);
    tick();
    mem_ce_i = 1'b0; mem_we_i = 1'b0; if_ce_i = 1'b0;

    // Reset while BUSY, then a late ack.
    if_ce_i = 1'b1; if_addr_i = 32'h40;
    tick();
    @(negedge clk);
    check_eq("t4_busy_req", 32'(bus_req_o), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_eq("t4_rsthi_stall", 32'(stallreq_o), 32'd0);
    tick();
    @(negedge clk);
    check_eq("t4_req",   32'(bus_req_o), 32'd0);
    check_eq("t4_addr",  bus_addr_o, 32'd0);
    check_eq("t4_sel",   32'(bus_sel_o), 32'd0);
    check_eq("t4_ifd",   if_data_o, 32'd0);
    tick();
    rst = 1'b0; if_ce_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    tick();
    bus_ack_i = 1'b0;
    @(negedge clk);
    check_eq("t4_late_req",   32'(bus_req_o), 32'd0);
    check_eq("t4_late_ifd",   if_data_o, 32'd0);
    check_eq("t4_late_memd",  mem_rdata_o, 32'd0);
    check_eq("t4_late_stall", 32'(stallreq_o), 32'd0);
    tick();

    // Spurious ack in IDLE, then ack held high across two transactions.
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0077;
    @(negedge clk);
    check_eq("t5_idle_stall", 32'(stallreq_o), 32'd0);
    tick();
    n_xfer = 0; bus_rdata_i = 32'h1111_1111;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h300;
    if_ce_i = 1'b1; if_addr_i = 32'h48;
    @(negedge clk);
    check_eq("t5_a_stall", 32'(stallreq_o), 32'd1);
    check_eq("t5_a_req",   32'(bus_req_o), 32'd0);
    tick();
    @(negedge clk);
    check_eq("t5_b_req",  32'(bus_req_o), 32'd1);
    check_eq("t5_b_addr", bus_addr_o, 32'h300);
    tick();
    bus_rdata_i = 32'h2222_2222;
    @(negedge clk);
    check_eq("t5_c_req",   32'(bus_req_o), 32'd0);
    check_eq("t5_c_stall", 32'(stallreq_o), 32'd1);
    check_eq("t5_c_memd",  mem_rdata_o, 32'h1111_1111);
    tick();
    @(negedge clk);
    check_eq("t5_d_req",  32'(bus_req_o), 32'd1);
    check_eq("t5_d_addr", bus_addr_o, 32'h48);
    tick();
    @(negedge clk);
    check_eq("t5_e_stall", 32'(stallreq_o), 32'd0);
    check_eq("t5_e_ifd",   if_data_o, 32'h2222_2222);
    check_eq("t5_e_memd",  mem_rdata_o, 32'h1111_1111);
    check_eq("t5_xfers",   32'(n_xfer), 32'd2);
    tick();
    bus_ack_i = 1'b0; mem_ce_i = 1'b0; if_ce_i = 1'b0;

`ifdef ARB_FETCH_BUF_EN
    // Held pc hits the buffer; a store to that word forces a refetch.
    if_ce_i = 1'b1; if_addr_i = 32'h20;
    serve("t6f", 1'b0, 4'hF, 32'h20, 32'h0, 0, 32'h0000_0099);
    @(negedge clk);
    check_eq("t6_rel_stall", 32'(stallreq_o), 32'd0);
    tick();
    @(negedge clk);
    check_eq("t6_hit_stall", 32'(stallreq_o), 32'd0);
    check_eq("t6_hit_req",   32'(bus_req_o), 32'd0);
    check_eq("t6_hit_ifd",   if_data_o, 32'h0000_0099);
    tick();
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'hF; mem_addr_i = 32'h20;
    mem_wdata_i = 32'h0000_1234;
    serve("t6s", 1'b1, 4'hF, 32'h20, 32'h0000_1234, 0, 32'h0);
    @(negedge clk);
    check_eq("t6_miss_stall", 32'(stallreq_o), 32'd1);
    check_eq("t6_miss_req",   32'(bus_req_o), 32'd0);
    serve("t6r", 1'b0, 4'hF, 32'h20, 32'h0, 0, 32'h0000_1234);
    @(negedge clk);
    check_eq("t6_rf_stall", 32'(stallreq_o), 32'd0);
    check_eq("t6_rf_ifd",   if_data_o, 32'h0000_1234);
    tick();
    mem_ce_i = 1'b0; mem_we_i = 1'b0; if_ce_i = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
